btn_reader: RTL and testbench

- Input-side counterpart of the LED counter on the iCEstick: it reads a raw mechanical pushbutton or PMOD input pin instead of driving outputs.
- Signal path: two-flop synchronizer, then a debounce state machine, then one-cycle press/release pulses and a wrapping press counter.
- The counter output is sized so it can drive `led[5:1]` directly from its top bits.

---
 rtl/btn_reader.sv | 129 ++++++++++++
 tb/tb_btn_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_reader.sv
// Pushbutton reader: two-flop synchronizer, debounce FSM, registered press/release
// strobes and a wrapping press counter sized to drive LEDs from its top bits.
module btn_reader #(
  parameter int N_STABLE = 16,
  parameter int N_COUNT  = 8,
  parameter bit POL_LOW  = 1'b0
) (
  input  logic               clk_100mhz,
  input  logic               rst_n,
  input  logic               btn_in,
  input  logic               count_clr,
  output logic               btn_level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic [N_COUNT-1:0] press_count
);

  localparam int CNT_W = $clog2(N_STABLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STABLE - 2);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_e;

  logic               sync1_q;
  logic               sync2_q;
  logic               pin_active;
  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               level_q,   level_d;
  logic               press_q,   press_d;
  logic               release_q, release_d;
  logic [N_COUNT-1:0] count_q,   count_d;

  assign pin_active = btn_in ^ POL_LOW;

  // NOTE: every flop, synchronizer included, is cleared by the async reset so an
  // interrupted debounce can never leak a pulse after rst_n deasserts.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      // NOTE: non-blocking so the two synchronizer stages shift by exactly one flop.
      sync1_q   <= pin_active;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register on the accepting edge.
    level_d   = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
    press_d   = (state_q == WAIT_HIGH) && (state_d == IDLE_HIGH);
    release_d = (state_q == WAIT_LOW)  && (state_d == IDLE_LOW);

    if (count_clr) begin
      count_d = '0;
    end else if (press_d) begin
      count_d = count_q + 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_btn_reader.sv
// Bench for btn_reader: run-length debounce model checked every cycle on an
// active-high and an active-low instance, plus directed literal checks.
module tb_btn_reader;

  localparam int N_STABLE = 4;
  localparam int N_COUNT  = 8;

  logic               clk_100mhz = 1'b0;
  logic               rst_n      = 1'b0;
  logic               btn_in     = 1'b0;
  logic               btn_in_n   = 1'b1;
  logic               count_clr  = 1'b0;
  logic               level_0, press_0, release_0;
  logic               level_1, press_1, release_1;
  logic [N_COUNT-1:0] count_0, count_1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk_100mhz = ~clk_100mhz;

  btn_reader #(.N_STABLE(N_STABLE), .N_COUNT(N_COUNT), .POL_LOW(1'b0)) dut (
    .clk_100mhz    (clk_100mhz),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .count_clr     (count_clr),
    .btn_level     (level_0),
    .press_pulse   (press_0),
    .release_pulse (release_0),
    .press_count   (count_0)
  );

  btn_reader #(.N_STABLE(N_STABLE), .N_COUNT(N_COUNT), .POL_LOW(1'b1)) dut_n (
    .clk_100mhz    (clk_100mhz),
    .rst_n         (rst_n),
    .btn_in        (btn_in_n),
    .count_clr     (count_clr),
    .btn_level     (level_1),
    .press_pulse   (press_1),
    .release_pulse (release_1),
    .press_count   (count_1)
  );

  // Reference: the pin is seen two edges late; the accepted level flips once the
  // synchronized pin has disagreed with it on N_STABLE consecutive edges.
  typedef struct packed {
    logic               q1;
    logic               s;
    logic               level;
    logic [7:0]         run;
    logic               press;
    logic               rel;
    logic [N_COUNT-1:0] count;
  } model_t;

  model_t m0, m1;

  function automatic model_t step(input model_t m, input logic p, input logic clr);
    model_t r;
    r       = m;
    r.press = 1'b0;
    r.rel   = 1'b0;
    if (m.s != m.level) begin
      r.run = m.run + 8'd1;
      if (int'(r.run) == N_STABLE) begin
        r.level = m.s;
        r.run   = '0;
        r.press = m.s;
        r.rel   = !m.s;
      end
    end else begin
      r.run = '0;
    end
    r.s  = m.q1;
    r.q1 = p;
    if (clr)          r.count = '0;
    else if (r.press) r.count = m.count + 1'b1;
    return r;
  endfunction

  always @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= step(m0, btn_in, count_clr);
      m1 <= step(m1, !btn_in_n, count_clr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_100mhz) begin
    if (chk_en) begin
      check("model level",   32'(level_0),   32'(m0.level));
      check("model press",   32'(press_0),   32'(m0.press));
      check("model release", 32'(release_0), 32'(m0.rel));
      check("model count",   32'(count_0),   32'(m0.count));
      check("model_n level",   32'(level_1),   32'(m1.level));
      check("model_n press",   32'(press_1),   32'(m1.press));
      check("model_n release", 32'(release_1), 32'(m1.rel));
      check("model_n count",   32'(count_1),   32'(m1.count));
    end
  end

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic clean_press(input int hold);
    btn_in = 1'b1;
    repeat (hold) tick();
    btn_in = 1'b0;
    repeat (hold) tick();
  endtask

  initial begin
    repeat (3) tick();
    check("reset level",   32'(level_0),   32'd0);
    check("reset press",   32'(press_0),   32'd0);
    check("reset count",   32'(count_0),   32'd0);
    check("reset level_n", 32'(level_1),   32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (4) tick();

    // Active-low pin: idle high, then held low.
    btn_in_n = 1'b0;
    repeat (5) tick();
    check("pol edge4 level", 32'(level_1), 32'd0);
    tick();
    check("pol edge5 press", 32'(press_1), 32'd1);
    check("pol edge5 level", 32'(level_1), 32'd1);
    check("pol edge5 count", 32'(count_1), 32'd1);
    btn_in_n = 1'b1;
    repeat (8) tick();

    // Glitch rejection: 3-cycle highs never accepted.
    for (int i = 0; i < 10; i++) begin
      btn_in = 1'b1;
      repeat (3) tick();
      btn_in = 1'b0;
      repeat (5) tick();
    end
    check("glitch level", 32'(level_0), 32'd0);
    check("glitch count", 32'(count_0), 32'd0);

    // Clean press with exact latency.
    btn_in = 1'b1;
    repeat (5) tick();
    check("press edge4 level", 32'(level_0), 32'd0);
    tick();
    check("press edge5 level", 32'(level_0), 32'd1);
    check("press edge5 pulse", 32'(press_0), 32'd1);
    tick();
    check("press edge6 pulse", 32'(press_0), 32'd0);
    check("press edge6 count", 32'(count_0), 32'd1);

    // 3-cycle dropout while pressed.
    btn_in = 1'b0;
    repeat (3) tick();
    btn_in = 1'b1;
    repeat (6) tick();
    check("dropout level", 32'(level_0),   32'd1);
    check("dropout rel",   32'(release_0), 32'd0);

    // Release with exact latency.
    btn_in = 1'b0;
    repeat (5) tick();
    check("release edge4 level", 32'(level_0), 32'd1);
    tick();
    check("release edge5 pulse", 32'(release_0), 32'd1);
    check("release edge5 level", 32'(level_0),   32'd0);
    tick();
    check("release edge6 pulse", 32'(release_0), 32'd0);
    check("release edge6 count", 32'(count_0),   32'd1);

    // Wrap after 256 presses from zero.
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    check("clear count", 32'(count_0), 32'd0);
    for (int i = 0; i < 255; i++) clean_press(7);
    check("wrap 255", 32'(count_0), 32'd255);
    clean_press(7);
    check("wrap 0", 32'(count_0), 32'd0);

    // Clear on the accepting edge beats the increment.
    clean_press(7);
    check("pre-clr count", 32'(count_0), 32'd1);
    btn_in = 1'b1;
    repeat (5) tick();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    check("clr-on-accept count", 32'(count_0), 32'd0);
    check("clr-on-accept pulse", 32'(press_0), 32'd1);
    btn_in = 1'b0;
    repeat (8) tick();

    // Randomized pin activity on both instances.
    for (int i = 0; i < 400; i++) begin
      int hold;
      hold      = $urandom_range(1, 8);
      btn_in    = ~btn_in;
      count_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) btn_in_n = ~btn_in_n;
      tick();
      count_clr = 1'b0;
      repeat (hold - 1) tick();
    end
    btn_in   = 1'b1;
    btn_in_n = 1'b1;
    repeat (10) tick();

    // Reset mid-debounce with the pin still held, then re-detection.
    btn_in = 1'b0;
    repeat (8) tick();
    btn_in = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    check("midrst level", 32'(level_0),   32'd0);
    check("midrst press", 32'(press_0),   32'd0);
    check("midrst rel",   32'(release_0), 32'd0);
    check("midrst count", 32'(count_0),   32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rerun edge4 level", 32'(level_0), 32'd0);
    tick();
    check("rerun edge5 level", 32'(level_0), 32'd1);
    check("rerun edge5 press", 32'(press_0), 32'd1);
    check("rerun edge5 count", 32'(count_0), 32'd1);
    repeat (4) tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
